// File: rtl/noc_alloc_pkg.sv
// Shared definitions for the NoC output port allocator: default sizes,
// the port index type and the per-output allocation state encoding.
package noc_alloc_pkg;

    localparam int DEF_CHANNEL_NUMBER       = 5;
    localparam int DEF_CHANNEL_NUMBER_WIDTH = $clog2(DEF_CHANNEL_NUMBER);
    localparam int DEF_LEN_WIDTH            = 8;

    typedef logic [DEF_CHANNEL_NUMBER_WIDTH-1:0] port_idx_t;

    typedef enum logic {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/output_port_allocator_if.sv
// Bundle between the input buffers / output muxes (master side) and the
// allocator (slave side).
//
// Handshake semantics: req_valid[i] says the head flit of input i is a routing
// header whose req_port/req_len slices are meaningful; the allocator answers by
// raising in_grant[i], which is the ready gating for that input. A flit of input
// i moves only in a cycle where the datapath sees valid && ready, and that event
// is reported back as in_fire[i]. Requests are level-held; nothing is consumed
// until a grant is visible, and in_fire on an ungranted input carries no meaning.
interface output_port_allocator_if #(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int LEN_WIDTH            = 8
);

    logic [CHANNEL_NUMBER-1:0]                      req_valid;
    logic [CHANNEL_NUMBER*CHANNEL_NUMBER_WIDTH-1:0] req_port;
    logic [CHANNEL_NUMBER*LEN_WIDTH-1:0]            req_len;
    logic [CHANNEL_NUMBER-1:0]                      in_fire;
    logic [CHANNEL_NUMBER-1:0]                      in_grant;
    logic [CHANNEL_NUMBER-1:0]                      out_locked;
    logic [CHANNEL_NUMBER*CHANNEL_NUMBER_WIDTH-1:0] out_sel;

    modport master (
        output req_valid, req_port, req_len, in_fire,
        input  in_grant, out_locked, out_sel
    );

    modport slave (
        input  req_valid, req_port, req_len, in_fire,
        output in_grant, out_locked, out_sel
    );

endinterface

// File: rtl/output_port_allocator_rr_picker.sv
// Combinational round-robin picker: returns the first requester strictly after
// the pointer, scanning upward with wrap-around, as one-hot and as an index.
module rr_picker #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan N positions starting one past the pointer; the first hit wins.
    always_comb begin : pick_blk
        int c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any      = 1'b1;
                idx      = c[W-1:0];
                grant[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// Packet-level switch allocator. Each output runs an IDLE/LOCKED FSM: in IDLE
// it picks one requesting, unallocated input in round-robin order; in LOCKED it
// counts that input's flits down from the header length and releases on the
// tail. out_locked is the registered FSM state of each output.
module output_port_allocator
    import noc_alloc_pkg::*;
#(
    parameter int CHANNEL_NUMBER       = DEF_CHANNEL_NUMBER,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int LEN_WIDTH            = DEF_LEN_WIDTH
) (
    input logic                    clk,
    input logic                    rst_n,
    output_port_allocator_if.slave bus
);

    localparam int N  = CHANNEL_NUMBER;
    localparam int CW = CHANNEL_NUMBER_WIDTH;
    localparam int LW = LEN_WIDTH;

    alloc_state_e  state_q [N];
    alloc_state_e  state_d [N];
    logic [CW-1:0] owner_q [N];
    logic [CW-1:0] owner_d [N];
    logic [CW-1:0] ptr_q   [N];
    logic [CW-1:0] ptr_d   [N];
    logic [LW-1:0] cnt_q   [N];
    logic [LW-1:0] cnt_d   [N];
    logic [N-1:0]  in_grant_q;
    logic [N-1:0]  in_grant_d;

    logic [N-1:0]  cand     [N];
    logic [N-1:0]  pick_oh  [N];
    logic [CW-1:0] pick_idx [N];
    logic          pick_any [N];

    // Candidate inputs per output: requesting this port and not already owning one.
    // Out-of-range port numbers never match any output and so are never served.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                cand[o][i] = bus.req_valid[i]
                          && (int'(bus.req_port[i*CW +: CW]) == o)
                          && !in_grant_q[i];
            end
        end
    end

    for (genvar o = 0; o < N; o++) begin : g_pick
        rr_picker #(
            .N (N),
            .W (CW)
        ) u_pick (
            .req   (cand[o]),
            .ptr   (ptr_q[o]),
            .grant (pick_oh[o]),
            .idx   (pick_idx[o]),
            .any   (pick_any[o])
        );
    end

    // Per-output next state, owner, flit count and RR pointer; input grants follow.
    always_comb begin
        in_grant_d = '0;
        for (int o = 0; o < N; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            cnt_d[o]   = cnt_q[o];
            ptr_d[o]   = ptr_q[o];
            if (state_q[o] == ALLOC_IDLE) begin
                if (pick_any[o]) begin
                    state_d[o] = ALLOC_LOCKED;
                    owner_d[o] = pick_idx[o];
                    // A zero length still carries the header flit.
                    if (bus.req_len[int'(pick_idx[o])*LW +: LW] == '0) begin
                        cnt_d[o] = LW'(1);
                    end else begin
                        cnt_d[o] = bus.req_len[int'(pick_idx[o])*LW +: LW];
                    end
                    in_grant_d = in_grant_d | pick_oh[o];
                end
            end else begin
                if (bus.in_fire[owner_q[o]] && (cnt_q[o] <= LW'(1))) begin
                    // Tail flit: release, and start the next search after this owner.
                    state_d[o] = ALLOC_IDLE;
                    ptr_d[o]   = owner_q[o];
                end else begin
                    if (bus.in_fire[owner_q[o]]) begin
                        cnt_d[o] = cnt_q[o] - LW'(1);
                    end
                    in_grant_d[owner_q[o]] = 1'b1;
                end
            end
        end
    end

    // State registers; reset drops every allocation and points RR at the last input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_grant_q <= '0;
            for (int o = 0; o < N; o++) begin
                state_q[o] <= ALLOC_IDLE;
                owner_q[o] <= '0;
                cnt_q[o]   <= '0;
                ptr_q[o]   <= CW'(N - 1);
            end
        end else begin
            in_grant_q <= in_grant_d;
            for (int o = 0; o < N; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                cnt_q[o]   <= cnt_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    // Outputs are straight copies of registers; out_sel keeps the last owner while IDLE.
    always_comb begin
        bus.in_grant = in_grant_q;
        for (int o = 0; o < N; o++) begin
            bus.out_locked[o]          = (state_q[o] == ALLOC_LOCKED);
            bus.out_sel[o*CW +: CW]    = owner_q[o];
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator: single packet, contention order,
// parallel grants, edge lengths, reset mid-packet and stray fires.
module tb_output_port_allocator;
    import noc_alloc_pkg::*;

    localparam int N  = 5;
    localparam int CW = 3;
    localparam int LW = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    output_port_allocator_if #(
        .CHANNEL_NUMBER       (N),
        .CHANNEL_NUMBER_WIDTH (CW),
        .LEN_WIDTH            (LW)
    ) bus ();

    output_port_allocator #(
        .CHANNEL_NUMBER       (N),
        .CHANNEL_NUMBER_WIDTH (CW),
        .LEN_WIDTH            (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_port  = '0;
        bus.req_len   = '0;
        bus.in_fire   = '0;
    endtask

    task automatic set_req(input int i, input int p, input int l);
        bus.req_valid[i]          = 1'b1;
        bus.req_port[i*CW +: CW]  = CW'(p);
        bus.req_len[i*LW +: LW]   = LW'(l);
    endtask

    function automatic port_idx_t get_sel(input int o);
        return bus.out_sel[o*CW +: CW];
    endfunction

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.in_grant !== 5'b00000) begin
            n_fail++; $display("FAIL reset_in_grant: got %b expected 00000", bus.in_grant);
        end
        n_checks++;
        if (bus.out_locked !== 5'b00000) begin
            n_fail++; $display("FAIL reset_out_locked: got %b expected 00000", bus.out_locked);
        end
        n_checks++;
        if (bus.out_sel !== 15'd0) begin
            n_fail++; $display("FAIL reset_out_sel: got %h expected 0", bus.out_sel);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_packet();
        do_reset();
        set_req(1, 3, 4);
        step();
        n_checks++;
        if (bus.out_locked !== 5'b01000 || get_sel(3) !== 3'd1 || bus.in_grant !== 5'b00010) begin
            n_fail++; $display("FAIL single_grant: locked=%b sel3=%0d grant=%b expected 01000/1/00010",
                               bus.out_locked, get_sel(3), bus.in_grant);
        end
        bus.req_valid = '0;
        bus.in_fire[1] = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            step();
            n_checks++;
            if (bus.out_locked[3] !== (f < 4)) begin
                n_fail++; $display("FAIL single_fire%0d: locked3=%b expected %b", f, bus.out_locked[3], (f < 4));
            end
        end
        bus.in_fire = '0;
        n_checks++;
        if (bus.in_grant !== 5'b00000 || get_sel(3) !== 3'd1) begin
            n_fail++; $display("FAIL single_release: grant=%b sel3=%0d expected 00000/1", bus.in_grant, get_sel(3));
        end
    endtask

    task automatic test_contention();
        logic [9:0]  exp_lock;
        logic [29:0] exp_sel;
        logic [2:0]  s;
        exp_lock = 10'b1011011011;
        exp_sel  = {3'd0, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0};
        do_reset();
        set_req(0, 2, 2);
        set_req(2, 2, 2);
        set_req(4, 2, 2);
        bus.in_fire = 5'b11111;
        for (int c = 0; c < 10; c++) begin
            step();
            s = exp_sel[c*3 +: 3];
            n_checks++;
            if (bus.out_locked[2] !== exp_lock[c] || get_sel(2) !== s) begin
                n_fail++; $display("FAIL contention_c%0d: locked2=%b sel2=%0d expected %b/%0d",
                                   c, bus.out_locked[2], get_sel(2), exp_lock[c], s);
            end
            n_checks++;
            if (bus.in_grant !== (exp_lock[c] ? (5'b00001 << s) : 5'b00000)) begin
                n_fail++; $display("FAIL contention_grant_c%0d: got %b", c, bus.in_grant);
            end
        end
        clear_inputs();
    endtask

    task automatic test_parallel();
        do_reset();
        set_req(0, 1, 3);
        set_req(1, 0, 3);
        step();
        n_checks++;
        if (bus.in_grant !== 5'b00011 || bus.out_locked !== 5'b00011) begin
            n_fail++; $display("FAIL parallel_grant: grant=%b locked=%b expected 00011/00011", bus.in_grant, bus.out_locked);
        end
        n_checks++;
        if (get_sel(1) !== 3'd0 || get_sel(0) !== 3'd1) begin
            n_fail++; $display("FAIL parallel_sel: sel1=%0d sel0=%0d expected 0/1", get_sel(1), get_sel(0));
        end
        bus.req_valid = '0;
        step();
        step();
        n_checks++;
        if (bus.out_locked !== 5'b00011) begin
            n_fail++; $display("FAIL parallel_hold: locked=%b expected 00011", bus.out_locked);
        end
        bus.in_fire = 5'b00011;
        step();
        step();
        n_checks++;
        if (bus.out_locked !== 5'b00011) begin
            n_fail++; $display("FAIL parallel_mid: locked=%b expected 00011", bus.out_locked);
        end
        step();
        n_checks++;
        if (bus.out_locked !== 5'b00000 || bus.in_grant !== 5'b00000) begin
            n_fail++; $display("FAIL parallel_release: locked=%b grant=%b expected 0/0", bus.out_locked, bus.in_grant);
        end
        clear_inputs();
    endtask

    task automatic test_edge_lengths();
        do_reset();
        set_req(2, 4, 0);
        set_req(3, 0, 1);
        set_req(1, 7, 5);
        step();
        n_checks++;
        if (bus.out_locked !== 5'b10001 || bus.in_grant !== 5'b01100) begin
            n_fail++; $display("FAIL edge_grant: locked=%b grant=%b expected 10001/01100", bus.out_locked, bus.in_grant);
        end
        bus.req_valid[2] = 1'b0;
        bus.req_valid[3] = 1'b0;
        bus.in_fire = 5'b01100;
        step();
        bus.in_fire = '0;
        n_checks++;
        if (bus.out_locked !== 5'b00000 || bus.in_grant !== 5'b00000) begin
            n_fail++; $display("FAIL edge_release: locked=%b grant=%b expected 0/0", bus.out_locked, bus.in_grant);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (bus.in_grant !== 5'b00000 || bus.out_locked !== 5'b00000) begin
                n_fail++; $display("FAIL edge_bad_port_c%0d: grant=%b locked=%b expected 0/0", c, bus.in_grant, bus.out_locked);
            end
        end
        clear_inputs();
    endtask

    task automatic test_stray_fire();
        do_reset();
        set_req(1, 3, 3);
        step();
        bus.req_valid = '0;
        bus.in_fire[4] = 1'b1;
        step();
        step();
        step();
        bus.in_fire = '0;
        n_checks++;
        if (bus.out_locked !== 5'b01000 || bus.in_grant !== 5'b00010 || get_sel(3) !== 3'd1) begin
            n_fail++; $display("FAIL stray_state: locked=%b grant=%b sel3=%0d expected 01000/00010/1",
                               bus.out_locked, bus.in_grant, get_sel(3));
        end
        bus.in_fire[1] = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.out_locked !== 5'b01000) begin
            n_fail++; $display("FAIL stray_count: locked=%b expected 01000 after 2 of 3 fires", bus.out_locked);
        end
        step();
        bus.in_fire = '0;
        n_checks++;
        if (bus.out_locked !== 5'b00000) begin
            n_fail++; $display("FAIL stray_release: locked=%b expected 00000", bus.out_locked);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_req(1, 3, 5);
        step();
        bus.req_valid = '0;
        bus.in_fire[1] = 1'b1;
        step();
        step();
        bus.in_fire = '0;
        n_checks++;
        if (bus.out_locked !== 5'b01000 || get_sel(3) !== 3'd1) begin
            n_fail++; $display("FAIL rstmid_pre: locked=%b sel3=%0d expected 01000/1", bus.out_locked, get_sel(3));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_locked !== 5'b00000 || bus.in_grant !== 5'b00000 || bus.out_sel !== 15'd0) begin
            n_fail++; $display("FAIL rstmid_async: locked=%b grant=%b sel=%h expected all 0",
                               bus.out_locked, bus.in_grant, bus.out_sel);
        end
        step();
        step();
        rst_n = 1'b1;
        set_req(0, 3, 2);
        set_req(1, 3, 2);
        set_req(4, 3, 2);
        step();
        n_checks++;
        if (bus.out_locked !== 5'b01000 || get_sel(3) !== 3'd0 || bus.in_grant !== 5'b00001) begin
            n_fail++; $display("FAIL rstmid_first_winner: locked=%b sel3=%0d grant=%b expected 01000/0/00001",
                               bus.out_locked, get_sel(3), bus.in_grant);
        end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_single_packet();
        test_contention();
        test_parallel();
        test_edge_lengths();
        test_stray_fire();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
